if_stage: RTL and testbench

//  RV32IM instruction-fetch stage plus IF/ID pipeline register; directly feeds id_stage (instr, pc+4).

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage_fetch_buffer.sv | 115 +++++++++++
 rtl/if_stage.sv | 142 ++++++++++++++
 tb/tb_if_stage.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the RV32IM instruction-fetch stage.
//   XLEN              : architectural register / address width
//   NOP_INSTR         : canonical NOP (addi x0, x0, 0) used for IF/ID bubbles
//   RESET_PC_DEFAULT  : default fetch address after reset
//   fb_entry_t        : one fetch-buffer slot {pc, instr, filled}
//   word_align()      : clears the byte-offset bits of an address
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fb_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// In-order fetch buffer: circular queue of FB_DEPTH slots {pc, instr, filled}.
//   clk, rst        : clock, synchronous active-high reset
//   clear_i         : drop every slot (redirect); an alloc in the same cycle lands after the clear
//   alloc_i/pc_i    : reserve the tail slot for a granted fetch
//   fill_i/instr_i  : write returned data into the oldest unfilled slot
//   pop_i           : retire the head slot (only honoured when the head is filled)
//   occupancy_o     : allocated slots (pending + filled)
//   pending_o       : allocated slots still waiting for data
//   head_*_c        : combinational view of the head slot
module if_stage_fetch_buffer
  import if_stage_pkg::*;
#(
  parameter  int unsigned FB_DEPTH = 2,
  localparam int unsigned PTR_W    = $clog2(FB_DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_instr_i,
  input  logic            pop_i,
  output logic [CNT_W-1:0] occupancy_o,
  output logic [CNT_W-1:0] pending_o,
  output logic            head_filled_c,
  output logic [XLEN-1:0] head_instr_c,
  output logic [XLEN-1:0] head_pc_c
);

  fb_entry_t [FB_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             fill_ok;
  logic             pop_ok;

  assign head_filled_c = (occ_q != '0) && mem_q[head_q].filled;
  assign head_instr_c  = mem_q[head_q].instr;
  assign head_pc_c     = mem_q[head_q].pc;
  assign occupancy_o   = occ_q;
  assign pending_o     = pend_q;

  // Fills only target slots already allocated; pops only retire filled heads.
  assign fill_ok = fill_i && (pend_q != '0);
  assign pop_ok  = pop_i && head_filled_c;

  // Next-state for slots, pointers and counters.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    occ_d  = occ_q;
    pend_d = pend_q;

    if (clear_i) begin
      mem_d  = '0;
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      occ_d  = '0;
      pend_d = '0;
      if (alloc_i) begin
        mem_d[0].pc     = alloc_pc_i;
        mem_d[0].instr  = NOP_INSTR;
        mem_d[0].filled = 1'b0;
        tail_d          = PTR_W'(1);
        occ_d           = CNT_W'(1);
        pend_d          = CNT_W'(1);
      end
    end else begin
      if (alloc_i) begin
        mem_d[tail_q].pc     = alloc_pc_i;
        mem_d[tail_q].instr  = NOP_INSTR;
        mem_d[tail_q].filled = 1'b0;
        tail_d               = tail_q + PTR_W'(1);
      end
      if (fill_ok) begin
        mem_d[fill_q].instr  = fill_instr_i;
        mem_d[fill_q].filled = 1'b1;
        fill_d               = fill_q + PTR_W'(1);
      end
      if (pop_ok) begin
        mem_d[head_q].filled = 1'b0;
        head_d               = head_q + PTR_W'(1);
      end
      occ_d  = occ_q + CNT_W'(alloc_i) - CNT_W'(pop_ok);
      pend_d = pend_q + CNT_W'(alloc_i) - CNT_W'(fill_ok);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      occ_q  <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      occ_q  <= occ_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32IM instruction-fetch stage with IF/ID pipeline register.
//   clk, rst            : clock, synchronous active-high reset
//   stall_i / flush_i   : hazard unit hold / bubble of IF/ID
//   redirect_i/_pc_i    : EX-resolved branch/jump target
//   imem_req_o/addr_o   : word fetch request (combinational)
//   imem_gnt_i          : request accepted this cycle
//   imem_rvalid_i/rdata : in-order read response
//   if_id_*_o           : IF/ID register (instr, pc+4, valid)
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     FB_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc_plus_4_o,
  output logic            if_id_valid_o
);

  localparam int unsigned CNT_W = $clog2(FB_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  pcp4_q, pcp4_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] pend;
  logic             head_filled;
  logic [XLEN-1:0]  head_instr;
  logic [XLEN-1:0]  head_pc;

  logic             req_acc;
  logic             drop_hit;
  logic             rvalid_used;
  logic             fill;
  logic             pop;
  logic [SUM_W-1:0] drop_sum;

  assign imem_req_o  = !rst && (occ < CNT_W'(FB_DEPTH));
  assign imem_addr_o = redirect_i ? word_align(redirect_pc_i) : pc_q;

  assign if_id_instr_o     = instr_q;
  assign if_id_pc_plus_4_o = pcp4_q;
  assign if_id_valid_o     = valid_q;

  // Response routing: stale responses are absorbed by drop_cnt, and any
  // response seen during a redirect belongs to the path being abandoned.
  assign req_acc     = imem_req_o && imem_gnt_i;
  assign drop_hit    = imem_rvalid_i && (drop_cnt_q != '0);
  assign rvalid_used = imem_rvalid_i && ((drop_cnt_q != '0) || (pend != '0));
  assign fill        = imem_rvalid_i && !drop_hit && !redirect_i && (pend != '0);
  assign pop         = !redirect_i && !flush_i && !stall_i && head_filled;
  assign drop_sum    = SUM_W'(drop_cnt_q) + SUM_W'(pend) - SUM_W'(rvalid_used);

  if_stage_fetch_buffer #(
    .FB_DEPTH(FB_DEPTH)
  ) u_fetch_buffer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (redirect_i),
    .alloc_i      (req_acc),
    .alloc_pc_i   (imem_addr_o),
    .fill_i       (fill),
    .fill_instr_i (imem_rdata_i),
    .pop_i        (pop),
    .occupancy_o  (occ),
    .pending_o    (pend),
    .head_filled_c(head_filled),
    .head_instr_c (head_instr),
    .head_pc_c    (head_pc)
  );

  // Fetch PC and stale-response bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;

    if (req_acc) begin
      pc_d = imem_addr_o + XLEN'(4);
    end else if (redirect_i) begin
      pc_d = imem_addr_o;
    end

    if (redirect_i) begin
      drop_cnt_d = CNT_W'(drop_sum);
    end else if (drop_hit) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // IF/ID register: redirect/flush bubble > stall hold > load head > bubble.
  always_comb begin
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;

    if (redirect_i || flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      instr_d = instr_q;
    end else if (head_filled) begin
      instr_d = head_instr;
      pcp4_d  = head_pc + XLEN'(4);
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= word_align(RESET_PC);
      drop_cnt_q <= '0;
      instr_q    <= NOP_INSTR;
      pcp4_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      instr_q    <= instr_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: 1-cycle in-order memory model plus a scoreboard of
// instructions expected to reach IF/ID, invalidated by redirect and reset.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pcp4;
  logic        if_id_valid;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .flush_i          (flush),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (gnt),
    .imem_rvalid_i    (rvalid),
    .imem_rdata_i     (rdata),
    .if_id_instr_o    (if_id_instr),
    .if_id_pc_plus_4_o(if_id_pcp4),
    .if_id_valid_o    (if_id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    bit          stale;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  mreq_t       cur_resp;
  bit          cur_valid;
  bit          mem_en;
  bit          force_stale;
  int          epoch;
  logic [31:0] model_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pcp4;
  int          n_acc;
  int          n_pop;
  int          checks;
  int          errors;

  logic        pre_req;
  logic        pre_rvalid;
  logic [31:0] pre_addr;
  logic        pre_rst;
  logic        pre_redirect;
  logic        pre_flush;
  logic        pre_stall;

  // Sampled mid-cycle: record the cycle's inputs, update memory/scoreboard model.
  task automatic pre();
    logic [31:0] exp_addr;
    pre_req      = imem_req;
    pre_rvalid   = rvalid;
    pre_addr     = imem_addr;
    pre_rst      = rst;
    pre_redirect = redirect;
    pre_flush    = flush;
    pre_stall    = stall;
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      epoch++;
      model_pc = 32'h0;
    end else begin
      if (cur_valid && !redirect && !cur_resp.stale && cur_resp.epoch == epoch)
        exp_q.push_back(cur_resp.addr);
      exp_addr = redirect ? {redirect_pc[31:2], 2'b00} : model_pc;
      if (redirect) begin
        exp_q.delete();
        epoch++;
      end
      checks++;
      if (imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_addr);
      end
      if (imem_req && gnt) begin
        mem_q.push_back('{addr: exp_addr, epoch: epoch, stale: 1'b0});
        model_pc = exp_addr + 32'd4;
        n_acc++;
      end else if (redirect) begin
        model_pc = exp_addr;
      end
    end
  endtask

  // Sampled just after the edge: check IF/ID, then drive next memory response.
  task automatic post();
    logic [31:0] e;
    if (pre_rst) begin
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR || if_id_pcp4 !== 32'h0) begin
        errors++;
        $display("FAIL reset_ifid: got v=%b i=%h p=%h expected v=0 i=%h p=0",
                 if_id_valid, if_id_instr, if_id_pcp4, NOP_INSTR);
      end
      m_valid = 1'b0; m_instr = NOP_INSTR; m_pcp4 = 32'h0;
    end else if (pre_redirect || pre_flush) begin
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR) begin
        errors++;
        $display("FAIL bubble: got v=%b i=%h expected v=0 i=%h", if_id_valid, if_id_instr, NOP_INSTR);
      end
      m_valid = 1'b0; m_instr = NOP_INSTR;
    end else if (pre_stall) begin
      checks++;
      if (if_id_valid !== m_valid || if_id_instr !== m_instr || (m_valid && if_id_pcp4 !== m_pcp4)) begin
        errors++;
        $display("FAIL stall_hold: got v=%b i=%h p=%h expected v=%b i=%h p=%h",
                 if_id_valid, if_id_instr, if_id_pcp4, m_valid, m_instr, m_pcp4);
      end
    end else if (if_id_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got i=%h p=%h expected none", if_id_instr, if_id_pcp4);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        if (if_id_instr !== e || if_id_pcp4 !== e + 32'd4) begin
          errors++;
          $display("FAIL ifid_data: got i=%h p=%h expected i=%h p=%h", if_id_instr, if_id_pcp4, e, e + 32'd4);
        end
        m_valid = 1'b1; m_instr = e; m_pcp4 = e + 32'd4;
      end
    end else begin
      checks++;
      if (if_id_instr !== NOP_INSTR) begin
        errors++;
        $display("FAIL idle_nop: got %h expected %h", if_id_instr, NOP_INSTR);
      end
      m_valid = 1'b0; m_instr = NOP_INSTR;
    end

    if (force_stale) begin
      cur_resp    = '{addr: 32'hDEAD_BEEC, epoch: epoch, stale: 1'b1};
      cur_valid   = 1'b1;
      rvalid      = 1'b1;
      rdata       = 32'hDEAD_BEEF;
      force_stale = 1'b0;
    end else if (mem_en && mem_q.size() > 0) begin
      cur_resp  = mem_q.pop_front();
      cur_valid = 1'b1;
      rvalid    = 1'b1;
      rdata     = cur_resp.addr;
    end else begin
      cur_valid = 1'b0;
      rvalid    = 1'b0;
      rdata     = 32'h0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    pre();
    @(posedge clk);
    #1;
    post();
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; gnt = 1'b0; mem_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    n_acc = 0;
    n_pop = 0;
  endtask

  task automatic run_until_valid(input int budget, output logic [31:0] pcp4, output int n);
    n = 0;
    pcp4 = 32'hx;
    while (n < budget) begin
      step();
      n++;
      if (if_id_valid === 1'b1) begin
        pcp4 = if_id_pcp4;
        break;
      end
    end
    checks++;
    if (if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout: got no valid within %0d cycles expected valid", budget);
    end
  endtask

  task automatic drain();
    int n;
    gnt = 1'b0; mem_en = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    n = 0;
    while (n < 40 && (mem_q.size() != 0 || exp_q.size() != 0 || cur_valid)) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d undelivered %0d outstanding expected 0 0", exp_q.size(), mem_q.size());
    end
  endtask

  task automatic test_reset();
    logic [31:0] p;
    int n;
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %b expected 0", imem_req);
    end
    do_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_req: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
    // abandon two in-flight fetches, then a late response arrives after reset
    gnt = 1'b1; mem_en = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    force_stale = 1'b1;
    step();
    rst = 1'b0;
    gnt = 1'b1; mem_en = 1'b1;
    n_acc = 0; n_pop = 0;
    run_until_valid(10, p, n);
    checks++;
    if (p !== 32'h4 || if_id_instr !== 32'h0) begin
      errors++;
      $display("FAIL late_rvalid: got p=%h i=%h expected p=00000004 i=00000000", p, if_id_instr);
    end
    drain();
  endtask

  task automatic test_stream();
    logic [31:0] p;
    int n;
    do_reset();
    gnt = 1'b1; mem_en = 1'b1;
    run_until_valid(10, p, n);
    checks++;
    if (n != 3 || p !== 32'h4) begin
      errors++;
      $display("FAIL first_latency: got cycle=%0d p=%h expected cycle=3 p=00000004", n, p);
    end
    step();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pcp4 !== 32'h8) begin
      errors++;
      $display("FAIL second_instr: got v=%b p=%h expected v=1 p=00000008", if_id_valid, if_id_pcp4);
    end
    repeat (20) step();
    drain();
    checks++;
    if (n_pop != n_acc) begin
      errors++;
      $display("FAIL stream_count: got %0d delivered expected %0d", n_pop, n_acc);
    end
  endtask

  task automatic test_no_gnt();
    logic [31:0] p;
    int n;
    do_reset();
    gnt = 1'b0; mem_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pre_req !== 1'b1 || pre_addr !== 32'h0 || if_id_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_gnt_%0d: got req=%b addr=%h v=%b expected 1 00000000 0", i, pre_req, pre_addr, if_id_valid);
      end
    end
    gnt = 1'b1;
    run_until_valid(10, p, n);
    checks++;
    if (p !== 32'h4) begin
      errors++;
      $display("FAIL no_gnt_resume: got %h expected 00000004", p);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [31:0] p;
    int n;
    do_reset();
    gnt = 1'b1; mem_en = 1'b1;
    run_until_valid(10, p, n);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pcp4 !== 32'h8) begin
        errors++;
        $display("FAIL stall_pc_%0d: got v=%b p=%h expected v=1 p=00000008", i, if_id_valid, if_id_pcp4);
      end
    end
    checks++;
    if (pre_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_req_drop: got %b expected 0", pre_req);
    end
    stall = 1'b0;
    step();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pcp4 !== 32'hC) begin
      errors++;
      $display("FAIL stall_release: got v=%b p=%h expected v=1 p=0000000c", if_id_valid, if_id_pcp4);
    end
    drain();
    checks++;
    if (n_pop != n_acc) begin
      errors++;
      $display("FAIL stall_count: got %0d delivered expected %0d", n_pop, n_acc);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] p;
    int n;
    do_reset();
    gnt = 1'b1; mem_en = 1'b0;
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0; mem_en = 1'b1;
    checks++;
    if (pre_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_full_req: got %b expected 0", pre_req);
    end
    run_until_valid(20, p, n);
    checks++;
    if (p !== 32'h104 || if_id_instr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_target: got p=%h i=%h expected p=00000104 i=00000100", p, if_id_instr);
    end
    drain();
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] p;
    int n;
    do_reset();
    gnt = 1'b1; mem_en = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    checks++;
    if (pre_req !== 1'b1 || pre_rvalid !== 1'b1 || pre_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_same: got req=%b rvalid=%b addr=%h expected 1 1 00000200", pre_req, pre_rvalid, pre_addr);
    end
    step();
    checks++;
    if (pre_req !== 1'b1 || pre_addr !== 32'h204) begin
      errors++;
      $display("FAIL redir_same_next: got req=%b addr=%h expected 1 00000204", pre_req, pre_addr);
    end
    run_until_valid(10, p, n);
    checks++;
    if (p !== 32'h204 || if_id_instr !== 32'h200) begin
      errors++;
      $display("FAIL redir_same_instr: got p=%h i=%h expected p=00000204 i=00000200", p, if_id_instr);
    end
    drain();
  endtask

  task automatic test_flush_stall();
    logic [31:0] p;
    int n;
    do_reset();
    gnt = 1'b1; mem_en = 1'b1;
    run_until_valid(10, p, n);
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR) begin
      errors++;
      $display("FAIL flush_stall: got v=%b i=%h expected v=0 i=%h", if_id_valid, if_id_instr, NOP_INSTR);
    end
    step();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pcp4 !== 32'h8) begin
      errors++;
      $display("FAIL flush_retain: got v=%b p=%h expected v=1 p=00000008", if_id_valid, if_id_pcp4);
    end
    drain();
    checks++;
    if (n_pop != n_acc) begin
      errors++;
      $display("FAIL flush_count: got %0d delivered expected %0d", n_pop, n_acc);
    end
  endtask

  initial begin
    checks = 0; errors = 0; epoch = 0; model_pc = 32'h0;
    mem_en = 1'b0; force_stale = 1'b0; cur_valid = 1'b0;
    m_valid = 1'b0; m_instr = NOP_INSTR; m_pcp4 = 32'h0;
    n_acc = 0; n_pop = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    test_reset();
    test_stream();
    test_no_gnt();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_flush_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
